// File: rtl/add3_serial_seq.sv
// Digit-serial WIDTH-bit adder: feeds one 3-bit digit per clock (LSB first)
// through a single add3bit ripple adder, with a start/busy/done handshake.

module add3bit (
  input  logic [2:0] A,
  input  logic [2:0] B,
  input  logic       Cin,
  output logic [2:0] Sum,
  output logic       Cout
);

  logic [3:0] c;

  always_comb begin
    c    = '0;
    Sum  = '0;
    c[0] = Cin;
    for (int i = 0; i < 3; i++) begin
      Sum[i]  = A[i] ^ B[i] ^ c[i];
      c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout = c[3];
  end

endmodule

module add3_serial_seq #(
  parameter  int unsigned WIDTH = 12,
  localparam int unsigned NDIG  = WIDTH / 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {IDLE, ADD} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   s_sh_q, s_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [2:0]         dig_sum;
  logic               dig_cout;
  logic [WIDTH-1:0]   s_next;

  add3bit u_add3bit (
    .A    (a_sh_q[2:0]),
    .B    (b_sh_q[2:0]),
    .Cin  (carry_q),
    .Sum  (dig_sum),
    .Cout (dig_cout)
  );

  // New digit enters at the top; shift form keeps WIDTH=3 legal.
  assign s_next = (s_sh_q >> 3) | (WIDTH'(dig_sum) << (WIDTH - 3));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          carry_d = Cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        s_sh_d  = s_next;
        a_sh_d  = a_sh_q >> 3;
        b_sh_d  = b_sh_q >> 3;
        carry_d = dig_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NDIG - 1)) begin
          sum_d   = s_next;
          cout_d  = dig_cout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule
